// File: rtl/sifh_pkg.sv
// Shared types and helpers for the dToF histogrammer.
// SIFH_SATURATE_EN selects a saturating bin increment instead of a wrapping one.
package sifh_pkg;

    typedef enum logic [1:0] {
        StClear,
        StAccum,
        StDrain,
        StReport
    } sifh_state_t;

    // Pixel index width; a single pixel still needs one bit.
    function automatic int unsigned pixW(input int unsigned pixels);
        return (pixels <= 1) ? 1 : $clog2(pixels);
    endfunction

    function automatic logic [31:0] incCount(input logic [31:0] cnt, input int unsigned cntW);
        logic [32:0] maxV;
        maxV = (33'd1 << cntW) - 33'd1;
`ifdef SIFH_SATURATE_EN
        return (cnt == maxV[31:0]) ? cnt : cnt + 32'd1;
`else
        return (cnt + 32'd1) & maxV[31:0];
`endif
    endfunction

endpackage

// File: rtl/sifh_hist_peak_if.sv
// Event input and peak report bundle between TDC capture and depth estimation.
interface sifh_hist_peak_if #(
    parameter int unsigned TDC_W = 10,
    parameter int unsigned BIN_W = 6,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PIX_W = 2
) ();
    logic             wrEn;
    logic [TDC_W-1:0] data;
    logic             rdy;
    logic             peak_valid;
    logic [PIX_W-1:0] peak_pixel;
    logic [BIN_W-1:0] peak_bin;
    logic [CNT_W-1:0] peak_count;

    modport master (
        output wrEn, data,
        input  rdy, peak_valid, peak_pixel, peak_bin, peak_count
    );

    modport slave (
        input  wrEn, data,
        output rdy, peak_valid, peak_pixel, peak_bin, peak_count
    );
endinterface

// File: rtl/sifh_bin_ram.sv
// Simple dual-port histogram RAM: read-first, one-cycle synchronous read.
module sifh_bin_ram #(
    parameter int unsigned BIN_W = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [BIN_W-1:0] wAddr_i,
    input  logic [CNT_W-1:0] wData_i,
    input  logic             re_i,
    input  logic [BIN_W-1:0] rAddr_i,
    output logic [CNT_W-1:0] rData_o
);
    logic [CNT_W-1:0] mem [2**BIN_W];

    // Same-address read and write in one cycle returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wAddr_i] <= wData_i;
        end
        if (re_i) begin
            rData_o <= mem[rAddr_i];
        end
    end
endmodule

// File: rtl/sifh_hist_peak.sv
// Per-pixel timestamp histogrammer with running peak tracking, round-robin over pixels.
// Increment behaviour depends on SIFH_SATURATE_EN (see sifh_pkg).
module sifh_hist_peak import sifh_pkg::*; #(
    parameter int unsigned TDC_W   = 10,
    parameter int unsigned BIN_W   = 6,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PIXELS  = 4,
    parameter int unsigned ACQ_NUM = 16
) (
    input  logic clk,
    input  logic res,
    sifh_hist_peak_if.slave bus
);
    localparam int unsigned PIX_W = pixW(PIXELS);
    localparam int unsigned EV_W  = $clog2(ACQ_NUM + 1);
    localparam logic [EV_W-1:0]  EvLast  = EV_W'(ACQ_NUM - 1);
    localparam logic [BIN_W-1:0] BinLast = '1;
    localparam logic [PIX_W-1:0] PixLast = PIX_W'(PIXELS - 1);

    sifh_state_t      state_q, state_d;
    logic [BIN_W-1:0] clrAddr_q, clrAddr_d;
    logic [EV_W-1:0]  evCnt_q, evCnt_d;
    logic [PIX_W-1:0] pix_q, pix_d;

    logic             s2Valid_q;
    logic [BIN_W-1:0] s2Bin_q;
    logic             fwdValid_q;
    logic [BIN_W-1:0] fwdBin_q;
    logic [CNT_W-1:0] fwdCnt_q;

    logic [BIN_W-1:0] peakBin_q, peakBin_d;
    logic [CNT_W-1:0] peakCnt_q, peakCnt_d;
    logic [PIX_W-1:0] outPix_q;
    logic [BIN_W-1:0] outBin_q;
    logic [CNT_W-1:0] outCnt_q;

    logic             accept;
    logic [BIN_W-1:0] evBin;
    logic [CNT_W-1:0] ramRdata, oldCnt, newCnt;
    logic             ramWe;
    logic [BIN_W-1:0] ramWAddr;
    logic [CNT_W-1:0] ramWData;
    logic             unusedData;

    assign bus.rdy        = (state_q == StAccum);
    assign bus.peak_valid = (state_q == StReport);
    assign bus.peak_pixel = outPix_q;
    assign bus.peak_bin   = outBin_q;
    assign bus.peak_count = outCnt_q;

    assign accept     = bus.wrEn && (state_q == StAccum);
    assign evBin      = bus.data[TDC_W-1 -: BIN_W];
    assign unusedData = ^bus.data;

    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        evCnt_d   = evCnt_q;
        pix_d     = pix_q;
        unique case (state_q)
            StClear: begin
                clrAddr_d = clrAddr_q + BIN_W'(1);
                evCnt_d   = '0;
                if (clrAddr_q == BinLast) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    evCnt_d = evCnt_q + EV_W'(1);
                    if (evCnt_q == EvLast) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StReport;
            StReport: begin
                pix_d   = (pix_q == PixLast) ? '0 : pix_q + PIX_W'(1);
                state_d = StClear;
            end
            default: state_d = StClear;
        endcase
    end

    // A same-bin write from the previous cycle is not yet visible in the read-first RAM.
    always_comb begin
        oldCnt = (fwdValid_q && (fwdBin_q == s2Bin_q)) ? fwdCnt_q : ramRdata;
        newCnt = CNT_W'(incCount(32'(oldCnt), CNT_W));
    end

    // Strict '>' keeps the earlier bin on ties; the same-bin term follows wrapped counts down.
    always_comb begin
        peakBin_d = peakBin_q;
        peakCnt_d = peakCnt_q;
        if (state_q == StClear) begin
            peakBin_d = '0;
            peakCnt_d = '0;
        end else if (s2Valid_q && ((newCnt > peakCnt_q) || (s2Bin_q == peakBin_q))) begin
            peakBin_d = s2Bin_q;
            peakCnt_d = newCnt;
        end
    end

    always_comb begin
        ramWe    = s2Valid_q;
        ramWAddr = s2Bin_q;
        ramWData = newCnt;
        if (state_q == StClear) begin
            ramWe    = 1'b1;
            ramWAddr = clrAddr_q;
            ramWData = '0;
        end
    end

    sifh_bin_ram #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .wAddr_i (ramWAddr),
        .wData_i (ramWData),
        .re_i    (accept),
        .rAddr_i (evBin),
        .rData_o (ramRdata)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= StClear;
            clrAddr_q  <= '0;
            evCnt_q    <= '0;
            pix_q      <= '0;
            s2Valid_q  <= 1'b0;
            s2Bin_q    <= '0;
            fwdValid_q <= 1'b0;
            fwdBin_q   <= '0;
            fwdCnt_q   <= '0;
            peakBin_q  <= '0;
            peakCnt_q  <= '0;
            outPix_q   <= '0;
            outBin_q   <= '0;
            outCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            clrAddr_q  <= clrAddr_d;
            evCnt_q    <= evCnt_d;
            pix_q      <= pix_d;
            s2Valid_q  <= accept;
            s2Bin_q    <= evBin;
            fwdValid_q <= s2Valid_q;
            fwdBin_q   <= s2Bin_q;
            fwdCnt_q   <= newCnt;
            peakBin_q  <= peakBin_d;
            peakCnt_q  <= peakCnt_d;
            // Capture the final peak (including the DRAIN write) so it is valid during REPORT.
            if (state_q == StDrain) begin
                outPix_q <= pix_q;
                outBin_q <= peakBin_d;
                outCnt_q <= peakCnt_d;
            end
        end
    end
endmodule
